// File: rtl/instr_fetch_align.sv
// instr_fetch_align: RV32IC instruction-fetch front end.
//
// Issues word-aligned reads to the unified memory, queues the returned halfwords in a
// four-slot buffer and presents one aligned instruction per cycle to decode. A 32-bit
// instruction may straddle a word boundary; it is only presented once both halves are
// buffered.
//
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   redirect_valid/redirect_pc  PC redirect from branch/jump/trap logic (highest priority)
//   mem_req/mem_addr            word read request and word-aligned address
//   mem_grant/mem_rdata         grant and same-cycle little-endian read data
//   instr_valid/instr_ready     handshake towards decode
//   instr/instr_pc              aligned instruction (compressed zero-extended) and its PC
//   instr_compressed            instr is a 16-bit encoding
module instr_fetch_align #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        mem_grant,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_compressed
);

    logic [31:0] faddr_q, faddr_d;
    logic [63:0] buf_q, buf_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        drop_half_q, drop_half_d;
    logic [31:0] pc_q, pc_d;

    logic [15:0] h0;
    logic        is_compressed;
    logic        valid_int;
    logic        fill;
    logic        consume;
    logic [2:0]  n_cons;
    logic [2:0]  rem;

    assign h0            = buf_q[15:0];
    assign is_compressed = (h0[1:0] != 2'b11);
    // A compressed instruction needs one slot, a full one needs two.
    assign valid_int     = ((cnt_q >= 3'd1) && is_compressed) || (cnt_q >= 3'd2);

    // Gate with rst so nothing leaks out while the reset is asserted.
    assign instr_valid      = rst && valid_int;
    assign instr_compressed = rst && is_compressed;
    assign instr            = !rst         ? 32'h0000_0000 :
                              is_compressed ? {16'h0000, h0} : buf_q[31:0];
    assign instr_pc         = pc_q;

    // Only request when a whole word is guaranteed to fit after any consume.
    assign mem_req  = rst && !redirect_valid && (cnt_q <= 3'd2);
    assign mem_addr = faddr_q;

    assign fill    = mem_req && mem_grant;
    assign consume = instr_valid && instr_ready && !redirect_valid;

    always_comb begin
        n_cons      = consume ? (is_compressed ? 3'd1 : 3'd2) : 3'd0;
        rem         = cnt_q - n_cons;
        buf_d       = buf_q >> {n_cons, 4'b0000};
        cnt_d       = rem;
        faddr_d     = faddr_q;
        drop_half_d = drop_half_q;
        pc_d        = pc_q + {28'h0, n_cons, 1'b0};

        // Append after the slots that survive this cycle's consume.
        if (fill) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) == rem) begin
                    buf_d[16*i +: 16] = drop_half_q ? mem_rdata[31:16] : mem_rdata[15:0];
                end else if (!drop_half_q && (3'(i) == rem + 3'd1)) begin
                    buf_d[16*i +: 16] = mem_rdata[31:16];
                end
            end
            cnt_d       = rem + (drop_half_q ? 3'd1 : 3'd2);
            drop_half_d = 1'b0;
            faddr_d     = faddr_q + 32'd4;
        end

        if (redirect_valid) begin
            buf_d       = buf_q;
            cnt_d       = 3'd0;
            pc_d        = redirect_pc & 32'hFFFF_FFFE;
            faddr_d     = redirect_pc & 32'hFFFF_FFFC;
            drop_half_d = redirect_pc[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            faddr_q     <= RESET_PC & 32'hFFFF_FFFC;
            buf_q       <= 64'h0;
            cnt_q       <= 3'd0;
            drop_half_q <= RESET_PC[1];
            pc_q        <= RESET_PC;
        end else begin
            faddr_q     <= faddr_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            drop_half_q <= drop_half_d;
            pc_q        <= pc_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_align.sv
// Bench for instr_fetch_align: a per-cycle vector table for the main stream (16/32-bit
// mix, straddle, grant stall, full buffer) plus hand-written redirect, grant-off and
// asynchronous-reset sequences. Memory is a small word array read combinationally.
module tb_instr_fetch_align;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_grant;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_compressed;

    logic [31:0] mem [128];

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_align dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .mem_grant        (mem_grant),
        .mem_rdata        (mem_rdata),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .instr_compressed (instr_compressed)
    );

    assign mem_rdata = mem[mem_addr[8:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        grant;
        logic        ready;
        logic        exp_valid;
        logic        chk_instr;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        logic        exp_comp;
        logic        exp_req;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs already driven; checks are taken before the next rising edge.
    task automatic chk_out(input string tag, input logic v, input logic ci, input logic [31:0] ins,
                           input logic [31:0] pc, input logic cmp, input logic req,
                           input logic [31:0] addr);
        chk({tag, ".valid"}, {31'h0, instr_valid}, {31'h0, v});
        chk({tag, ".req"}, {31'h0, mem_req}, {31'h0, req});
        chk({tag, ".addr"}, mem_addr, addr);
        chk({tag, ".pc"}, instr_pc, pc);
        if (ci) begin
            chk({tag, ".instr"}, instr, ins);
            chk({tag, ".comp"}, {31'h0, instr_compressed}, {31'h0, cmp});
        end
    endtask

    task automatic drive(input logic g, input logic r);
        mem_grant   = g;
        instr_ready = r;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[0]  = 32'h0000_0013;
        mem[1]  = 32'h0010_0093;
        mem[2]  = 32'h4501_4501;
        mem[3]  = 32'h0513_4501;  // c.li @0xC, low half of 0x00A00513 @0xE
        mem[4]  = 32'h4501_00A0;  // high half of the straddler, c.li @0x12
        mem[5]  = 32'h0000_0013;
        mem[6]  = 32'h0010_0093;
        mem[7]  = 32'h0000_0013;
        mem[65] = 32'h4505_DEAD;  // 0x104: low half dropped after redirect to 0x106
        mem[66] = 32'h0010_0093;
        mem[67] = 32'h4501_4501;
        mem[68] = 32'h0000_0013;

        //           g     r     v     ci    instr          pc          cmp   req   addr
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h00,     1'b0, 1'b1, 32'h00};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0013, 32'h00,     1'b0, 1'b1, 32'h04};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0010_0093, 32'h04,     1'b0, 1'b1, 32'h08};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_4501, 32'h08,     1'b1, 1'b1, 32'h0C};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_4501, 32'h0A,     1'b1, 1'b0, 32'h10};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_4501, 32'h0C,     1'b1, 1'b1, 32'h10};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0E,     1'b0, 1'b1, 32'h10};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0E,     1'b0, 1'b1, 32'h10};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h00A0_0513, 32'h0E,     1'b0, 1'b0, 32'h14};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_4501, 32'h12,     1'b1, 1'b1, 32'h14};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0013, 32'h14,     1'b0, 1'b1, 32'h18};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0013, 32'h14,     1'b0, 1'b0, 32'h1C};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0010_0093, 32'h18,     1'b0, 1'b1, 32'h1C};

        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mem_grant      = 1'b1;
        instr_ready    = 1'b1;
        @(negedge clk);
        #1;
        chk("rst.valid", {31'h0, instr_valid}, 32'h0);
        chk("rst.req", {31'h0, mem_req}, 32'h0);
        chk("rst.instr", instr, 32'h0);
        chk("rst.comp", {31'h0, instr_compressed}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].grant, vecs[i].ready);
            chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].chk_instr,
                    vecs[i].exp_instr, vecs[i].exp_pc, vecs[i].exp_comp, vecs[i].exp_req,
                    vecs[i].exp_addr);
            @(negedge clk);
        end

        // Redirect to 0x106: no request during the redirect cycle itself.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0106;
        drive(1'b1, 1'b1);
        chk("redir.req", {31'h0, mem_req}, 32'h0);
        @(negedge clk);
        redirect_valid = 1'b0;
        drive(1'b1, 1'b0);
        chk_out("redir1", 1'b0, 1'b0, 32'h0, 32'h106, 1'b0, 1'b1, 32'h104);
        @(negedge clk);
        drive(1'b0, 1'b1);
        chk_out("redir2", 1'b1, 1'b1, 32'h4505, 32'h106, 1'b1, 1'b1, 32'h108);
        @(negedge clk);

        // Grant withheld: buffer drains, address holds, then resumes there.
        drive(1'b0, 1'b1);
        chk_out("nogr1", 1'b0, 1'b0, 32'h0, 32'h108, 1'b0, 1'b1, 32'h108);
        @(negedge clk);
        drive(1'b0, 1'b1);
        chk_out("nogr2", 1'b0, 1'b0, 32'h0, 32'h108, 1'b0, 1'b1, 32'h108);
        @(negedge clk);
        drive(1'b1, 1'b1);
        chk_out("resume", 1'b0, 1'b0, 32'h0, 32'h108, 1'b0, 1'b1, 32'h108);
        @(negedge clk);
        drive(1'b1, 1'b1);
        chk_out("res1", 1'b1, 1'b1, 32'h0010_0093, 32'h108, 1'b0, 1'b1, 32'h10C);
        @(negedge clk);
        drive(1'b1, 1'b1);
        chk_out("res2", 1'b1, 1'b1, 32'h4501, 32'h10C, 1'b1, 1'b1, 32'h110);
        @(negedge clk);

        // cnt=3 now; assert reset between edges.
        drive(1'b0, 1'b0);
        chk_out("cnt3", 1'b1, 1'b1, 32'h4501, 32'h10E, 1'b1, 1'b0, 32'h114);
        #1;
        rst = 1'b0;
        #1;
        chk("arst.valid", {31'h0, instr_valid}, 32'h0);
        chk("arst.req", {31'h0, mem_req}, 32'h0);
        chk("arst.instr", instr, 32'h0);
        chk("arst.addr", mem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b1);
        chk_out("restart", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b1);
        chk_out("restart1", 1'b1, 1'b1, 32'h0000_0013, 32'h0, 1'b0, 1'b1, 32'h4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
